// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types, byte-strobe merge.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace each byte of old_v whose strobe bit is set with the matching byte of new_v.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regbank_slv.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit registers with byte strobes,
// independent write and read channel FSMs, all AXI outputs registered.
module axil_regbank_slv
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [32*NUM_REGS-1:0]  regs_o,
  output logic [NUM_REGS-1:0]     wr_pulse_o
);

  localparam int IDX_W = ADDR_W - 2;

  // Byte-offset bits never select anything; they are deliberately dropped.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------------------------------------------------------- write side
  wr_state_t        w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             awready_q, awready_d, wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  logic             aw_fire, w_fire, commit, b_done, cm_hit;
  logic [IDX_W-1:0] cm_idx;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;

  logic [31:0]         regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;

  // Handshake decode and selection of the address/data that a commit uses (held or live).
  always_comb begin
    aw_fire = s_axi_awvalid && awready_q;
    w_fire  = s_axi_wvalid && wready_q;
    commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    b_done  = (w_state_q == W_RESP) && s_axi_bready;
    cm_idx  = aw_held_q ? aw_idx_q : s_axi_awaddr[ADDR_W-1:2];
    cm_data = w_held_q ? wdata_q : s_axi_wdata;
    cm_strb = w_held_q ? wstrb_q : s_axi_wstrb;
    cm_hit  = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cm_idx == IDX_W'(k)) cm_hit = 1'b1;
    end
  end

  // Write FSM state register plus captured AW/W and registered write-channel outputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state: commit moves to response, B handshake returns to idle.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (commit) w_state_d = W_RESP;
      W_RESP:  if (b_done) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: capture AW/W independently, raise B on commit, reopen on B handshake.
  // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = cm_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (b_done) begin
      awready_d = 1'b1;
      wready_d  = 1'b1;
      bvalid_d  = 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        aw_idx_d  = s_axi_awaddr[ADDR_W-1:2];
        awready_d = 1'b0;
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        wdata_d  = s_axi_wdata;
        wstrb_d  = s_axi_wstrb;
        wready_d = 1'b0;
      end
    end
  end

  // Register array and per-register write pulse; out-of-range commits touch nothing.
  // NOTE: the array is reset because its contents are visible on regs_o straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        wr_pulse_q[k] <= commit && (cm_idx == IDX_W'(k));
        if (commit && (cm_idx == IDX_W'(k))) begin
          regs_q[k] <= strb_merge(regs_q[k], cm_data, cm_strb);
        end
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_t        r_state_q, r_state_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             ar_fire, r_done, rd_hit;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_mux;

  // Read handshake decode and register lookup (array value before any same-edge write).
  always_comb begin
    ar_fire = s_axi_arvalid && arready_q;
    r_done  = (r_state_q == R_DATA) && s_axi_rready;
    ar_idx  = s_axi_araddr[ADDR_W-1:2];
    rd_hit  = 1'b0;
    rd_mux  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_hit = 1'b1;
        rd_mux = regs_q[k];
      end
    end
  end

  // Read FSM state register and registered read-channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read FSM next state: AR handshake to data phase, R handshake back to idle.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_state_d = R_DATA;
      R_DATA:  if (r_done) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs: load data/response on AR handshake, hold them until R handshake.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_fire) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_mux;
      rresp_d   = rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (r_done) begin
      arready_d = 1'b1;
      rvalid_d  = 1'b0;
    end
  end

  // ------------------------------------------------------------------- outputs
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_axil_regbank_slv.sv
// Self-checking bench for axil_regbank_slv: directed vector table, randomized traffic
// against an array-based register model, and hand sequences for the multi-cycle cases.
module tb_axil_regbank_slv;

  localparam int ADDR_W   = 16;
  localparam int NUM_REGS = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_W-1:0]      s_axi_awaddr;
  logic                   s_axi_awvalid, s_axi_awready;
  logic [31:0]            s_axi_wdata;
  logic [3:0]             s_axi_wstrb;
  logic                   s_axi_wvalid, s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid, s_axi_bready;
  logic [ADDR_W-1:0]      s_axi_araddr;
  logic                   s_axi_arvalid, s_axi_arready;
  logic [31:0]            s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid, s_axi_rready;
  logic [32*NUM_REGS-1:0] regs_o;
  logic [NUM_REGS-1:0]    wr_pulse_o;

  axil_regbank_slv #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_regs [NUM_REGS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: registers are plain words, index is the word offset.
  task automatic model_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [31:0] pulse);
    int idx;
    idx = int'(addr) / 4;
    if (idx < NUM_REGS) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      end
      resp  = OKAY;
      pulse = 32'd1 << idx;
    end else begin
      resp  = SLVERR;
      pulse = 32'd0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    int idx;
    idx = int'(addr) / 4;
    return (idx < NUM_REGS) ? model_regs[idx] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 32'd0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int k = 0; k < NUM_REGS; k++) check(tag, regs_o[32*k +: 32], model_regs[k]);
  endtask

  // AXI master write with AW and W presented together; returns the sampled B and pulse.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [31:0] pulse);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1; n++;
      if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  s_axi_wvalid = 1'b0; end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("wr_handshake", 32'({aw_done, w_done}), 32'h3);
    check("bvalid_after_commit", 32'(s_axi_bvalid), 32'd1);
    resp  = s_axi_bresp;
    pulse = 32'(wr_pulse_o);
    @(posedge clk); #1;
    check("bvalid_cleared", 32'(s_axi_bvalid), 32'd0);
    check("wr_pulse_one_cycle", 32'(wr_pulse_o), 32'd0);
  endtask

  // AXI master read; rvalid must be up right after the AR handshake edge.
  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done, hs;
    int n;
    done = 0; n = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    while (!done && n < 20) begin
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1; n++;
      if (hs) begin done = 1; s_axi_arvalid = 1'b0; end
    end
    s_axi_arvalid = 1'b0;
    check("rd_handshake", 32'(done), 32'd1);
    check("rvalid_latency1", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge clk); #1;
    check("rvalid_cleared", 32'(s_axi_rvalid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] pulse;
    logic [15:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, mresp;
    logic [31:0] pulse, mpulse, rdata;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;

    vecs[0] = '{16'h0008, 32'hCAFE_F00D, 4'hF, OKAY,   32'h0004, 16'h0008, 32'hCAFE_F00D, OKAY};
    vecs[1] = '{16'h0008, 32'h1122_3344, 4'h5, OKAY,   32'h0004, 16'h0008, 32'hCA22_F044, OKAY};
    vecs[2] = '{16'h0040, 32'hDEAD_BEEF, 4'hF, SLVERR, 32'h0000, 16'h0040, 32'h0000_0000, SLVERR};
    vecs[3] = '{16'h003C, 32'h1234_5678, 4'h8, OKAY,   32'h8000, 16'h003C, 32'h1200_0000, OKAY};
    vecs[4] = '{16'h0000, 32'hAABB_CCDD, 4'h0, OKAY,   32'h0001, 16'h0000, 32'h0000_0000, OKAY};
    vecs[5] = '{16'h0007, 32'h0102_0304, 4'hF, OKAY,   32'h0002, 16'h0004, 32'h0102_0304, OKAY};

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_awready", 32'(s_axi_awready), 32'd1);
    check("rst_wready", 32'(s_axi_wready), 32'd1);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    check("rst_pulse", 32'(wr_pulse_o), 32'd0);
    check_all_regs("rst_regs");

    // Directed vector table: write, read back, compare against constants and model
    for (int i = 0; i < 6; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
      model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp, mpulse);
      check("vec_bresp", 32'(resp), 32'(vecs[i].bresp));
      check("vec_pulse", pulse, vecs[i].pulse);
      check_all_regs("vec_regs");
      axi_read(vecs[i].raddr, rdata, resp);
      check("vec_rdata", rdata, vecs[i].rdata);
      check("vec_rresp", 32'(resp), 32'(vecs[i].rresp));
    end

    // Randomized traffic, including out-of-range addresses
    for (int i = 0; i < 30; i++) begin
      addr = 16'($urandom_range(0, 79));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      axi_write(addr, data, strb, resp, pulse);
      model_write(addr, data, strb, mresp, mpulse);
      check("rnd_bresp", 32'(resp), 32'(mresp));
      check("rnd_pulse", pulse, mpulse);
      addr = 16'($urandom_range(0, 79));
      axi_read(addr, rdata, resp);
      check("rnd_rdata", rdata, model_read(addr));
      check("rnd_rresp", 32'(resp), (int'(addr) / 4 < NUM_REGS) ? 32'(OKAY) : 32'(SLVERR));
    end
    check_all_regs("rnd_regs");

    // W three cycles ahead of AW, then B back-pressured for five cycles
    s_axi_bready = 1'b0;
    s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    check("wfirst_wready_low", 32'(s_axi_wready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("wfirst_awready", 32'(s_axi_awready), 32'd1);
      check("wfirst_no_b", 32'(s_axi_bvalid), 32'd0);
    end
    s_axi_awaddr = 16'h000C; s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    model_write(16'h000C, 32'h0BAD_F00D, 4'hF, mresp, mpulse);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
      check("bp_bresp", 32'(s_axi_bresp), 32'(OKAY));
      check("bp_readies", 32'({s_axi_awready, s_axi_wready}), 32'd0);
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    check("bp_bvalid_done", 32'(s_axi_bvalid), 32'd0);
    check("bp_readies_back", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    check("bp_reg3", regs_o[32*3 +: 32], model_regs[3]);

    // Read on the same edge as a write commit to the same register sees the old value
    axi_write(16'h0004, 32'd5, 4'hF, resp, pulse);
    model_write(16'h0004, 32'd5, 4'hF, mresp, mpulse);
    check("race_pre_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    s_axi_awaddr = 16'h0004; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'd9; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 16'h0004; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("race_rvalid", 32'(s_axi_rvalid), 32'd1);
    check("race_old_data", s_axi_rdata, 32'd5);
    check("race_bvalid", 32'(s_axi_bvalid), 32'd1);
    model_write(16'h0004, 32'd9, 4'hF, mresp, mpulse);
    @(posedge clk); #1;
    check("race_both_done", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    axi_read(16'h0004, rdata, resp);
    check("race_new_data", rdata, 32'd9);

    // Reset while both responses are pending
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 16'h0010; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 16'h0010; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("pre_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h3);
    rst = 1'b1;
    #2;
    model_reset();
    check("async_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    check("async_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    check_all_regs("async_rst_regs");
    @(posedge clk); #1;
    rst = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_resp", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    check("post_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    axi_write(16'h0000, 32'h5A5A_A5A5, 4'hF, resp, pulse);
    model_write(16'h0000, 32'h5A5A_A5A5, 4'hF, mresp, mpulse);
    check("post_rst_bresp", 32'(resp), 32'(OKAY));
    check("post_rst_pulse", pulse, 32'h1);
    axi_read(16'h0000, rdata, resp);
    check("post_rst_rdata", rdata, model_read(16'h0000));
    check("post_rst_rresp", 32'(resp), 32'(OKAY));
    check_all_regs("final_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
